mastermind_core_p: RTL and testbench

Parametrised next-generation Mastermind game controller.
- Supports any number of pegs, any colour width and any guess limit.
- Adds black/white-peg scoring (exact and colour-only matches) and a restart path from the done states.
- Sits between the switch/button debouncers and the display/feedback logic, in the same slot as the fixed 4-peg core.

---
 rtl/mastermind_core_p_if.sv | 42 ++++
 rtl/mastermind_core_p.sv | 172 +++++++++++++++++
 tb/tb_mastermind_core_p.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mastermind_core_p_if.sv
// rtl/mastermind_core_p_if.sv - control, code and score signal bundle for mastermind_core_p
interface mastermind_core_p_if #(
  parameter int NPEGS       = 4,
  parameter int CW          = 3,
  parameter int MAX_GUESSES = 6
);
  localparam int IW = ($clog2(NPEGS) > 1) ? $clog2(NPEGS) : 1;
  localparam int GW = ($clog2(MAX_GUESSES) > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int SW = $clog2(NPEGS + 1);

  logic                  start;
  logic [NPEGS*CW-1:0]   correct_answer;
  logic [CW-1:0]         current_color;
  logic                  confirm_color;
  logic                  check_guess;
  logic                  BtnL;
  logic                  BtnR;
  logic [IW-1:0]         index;
  logic [GW-1:0]         guess_num;
  logic [NPEGS*CW-1:0]   current_guess;
  logic [SW-1:0]         exact_cnt;
  logic [SW-1:0]         partial_cnt;
  logic                  score_valid;
  logic                  q_Start;
  logic                  q_Input;
  logic                  q_Score;
  logic                  q_Check;
  logic                  q_DoneC;
  logic                  q_DoneNC;

  modport master (
    output start, correct_answer, current_color, confirm_color, check_guess, BtnL, BtnR,
    input  index, guess_num, current_guess, exact_cnt, partial_cnt, score_valid,
    input  q_Start, q_Input, q_Score, q_Check, q_DoneC, q_DoneNC
  );

  modport slave (
    input  start, correct_answer, current_color, confirm_color, check_guess, BtnL, BtnR,
    output index, guess_num, current_guess, exact_cnt, partial_cnt, score_valid,
    output q_Start, q_Input, q_Score, q_Check, q_DoneC, q_DoneNC
  );
endinterface

// File: rtl/mastermind_core_p.sv
// rtl/mastermind_core_p.sv - parametrised Mastermind controller with black/white-peg scoring
module mastermind_core_p #(
  parameter int NPEGS         = 4,
  parameter int CW            = 3,
  parameter int MAX_GUESSES   = 6,
  parameter int CLEAR_ON_NEXT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  mastermind_core_p_if.slave bus
);
  localparam int IW = ($clog2(NPEGS) > 1) ? $clog2(NPEGS) : 1;
  localparam int GW = ($clog2(MAX_GUESSES) > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int SW = $clog2(NPEGS + 1);
  localparam int DW = NPEGS * CW;

  localparam logic [IW-1:0] IDX_MAX    = IW'(NPEGS - 1);
  localparam logic [GW-1:0] LAST_GUESS = GW'(MAX_GUESSES - 1);
  localparam logic [CW-1:0] COL_FIRST  = CW'(1);
  localparam logic [CW-1:0] COL_LAST   = '1;
  localparam logic [SW-1:0] ALL_EXACT  = SW'(NPEGS);

  typedef enum logic [2:0] {
    S_START, S_INPUT, S_SCORE, S_CHECK, S_DONEC, S_DONENC
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   target_q, target_d;
  logic [DW-1:0]   guess_q, guess_d;
  logic [IW-1:0]   index_q, index_d;
  logic [GW-1:0]   guess_num_q, guess_num_d;
  logic [SW-1:0]   exact_q, exact_d;
  logic [SW-1:0]   partial_q, partial_d;
  logic            score_valid_q, score_valid_d;
  logic [CW-1:0]   color_q, color_d;
  logic [SW-1:0]   exact_acc_q, exact_acc_d;
  logic [SW-1:0]   match_acc_q, match_acc_d;

  logic            all_filled;
  logic [SW-1:0]   exact_now;
  logic [SW-1:0]   cnt_guess;
  logic [SW-1:0]   cnt_target;
  logic [SW-1:0]   min_cnt;
  logic [SW-1:0]   exact_use;
  logic [SW-1:0]   match_sum;

  // Per-peg scan: fill status, positional matches, and occurrences of the colour under scan.
  always_comb begin
    all_filled = 1'b1;
    exact_now  = '0;
    cnt_guess  = '0;
    cnt_target = '0;
    for (int i = 0; i < NPEGS; i++) begin
      if (guess_q[i*CW +: CW] == '0) all_filled = 1'b0;
      if (guess_q[i*CW +: CW] == target_q[i*CW +: CW]) exact_now = exact_now + SW'(1);
      if (guess_q[i*CW +: CW] == color_q) cnt_guess = cnt_guess + SW'(1);
      if (target_q[i*CW +: CW] == color_q) cnt_target = cnt_target + SW'(1);
    end
    min_cnt   = (cnt_guess < cnt_target) ? cnt_guess : cnt_target;
    // Exact count is taken on the first scoring cycle; later cycles reuse the stored value.
    exact_use = (color_q == COL_FIRST) ? exact_now : exact_acc_q;
    match_sum = match_acc_q + min_cnt;
  end

  // Next-state and datapath updates for every game phase.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    guess_d       = guess_q;
    index_d       = index_q;
    guess_num_d   = guess_num_q;
    exact_d       = exact_q;
    partial_d     = partial_q;
    score_valid_d = 1'b0;
    color_d       = color_q;
    exact_acc_d   = exact_acc_q;
    match_acc_d   = match_acc_q;
    case (state_q)
      S_START: begin
        target_d    = bus.correct_answer;
        guess_d     = '0;
        index_d     = '0;
        guess_num_d = '0;
        exact_d     = '0;
        partial_d   = '0;
        state_d     = S_INPUT;
      end
      S_INPUT: begin
        if (bus.check_guess && all_filled) begin
          color_d     = COL_FIRST;
          exact_acc_d = '0;
          match_acc_d = '0;
          state_d     = S_SCORE;
        end else begin
          // The colour write uses the cursor position from before this cycle's move.
          if (bus.confirm_color) guess_d[int'(index_q)*CW +: CW] = bus.current_color;
          if (bus.BtnR && !bus.BtnL && index_q != IDX_MAX) index_d = index_q + IW'(1);
          else if (bus.BtnL && !bus.BtnR && index_q != '0) index_d = index_q - IW'(1);
        end
      end
      S_SCORE: begin
        exact_acc_d = exact_use;
        match_acc_d = match_sum;
        color_d     = color_q + CW'(1);
        if (color_q == COL_LAST) begin
          exact_d       = exact_use;
          partial_d     = match_sum - exact_use;
          score_valid_d = 1'b1;
          state_d       = S_CHECK;
        end
      end
      S_CHECK: begin
        if (exact_q == ALL_EXACT) begin
          state_d = S_DONEC;
        end else if (guess_num_q == LAST_GUESS) begin
          state_d = S_DONENC;
        end else begin
          guess_num_d = guess_num_q + GW'(1);
          index_d     = '0;
          if (CLEAR_ON_NEXT != 0) guess_d = '0;
          state_d     = S_INPUT;
        end
      end
      S_DONEC, S_DONENC: begin
        if (bus.start) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_START;
      target_q      <= '0;
      guess_q       <= '0;
      index_q       <= '0;
      guess_num_q   <= '0;
      exact_q       <= '0;
      partial_q     <= '0;
      score_valid_q <= 1'b0;
      color_q       <= '0;
      exact_acc_q   <= '0;
      match_acc_q   <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      guess_q       <= guess_d;
      index_q       <= index_d;
      guess_num_q   <= guess_num_d;
      exact_q       <= exact_d;
      partial_q     <= partial_d;
      score_valid_q <= score_valid_d;
      color_q       <= color_d;
      exact_acc_q   <= exact_acc_d;
      match_acc_q   <= match_acc_d;
    end
  end

  assign bus.index         = index_q;
  assign bus.guess_num     = guess_num_q;
  assign bus.current_guess = guess_q;
  assign bus.exact_cnt     = exact_q;
  assign bus.partial_cnt   = partial_q;
  assign bus.score_valid   = score_valid_q;
  assign bus.q_Start       = (state_q == S_START);
  assign bus.q_Input       = (state_q == S_INPUT);
  assign bus.q_Score       = (state_q == S_SCORE);
  assign bus.q_Check       = (state_q == S_CHECK);
  assign bus.q_DoneC       = (state_q == S_DONEC);
  assign bus.q_DoneNC      = (state_q == S_DONENC);
endmodule

// File: tb/tb_mastermind_core_p.sv
// tb/tb_mastermind_core_p.sv - scoreboard bench for mastermind_core_p
module tb_mastermind_core_p;
  localparam int NPEGS = 4;
  localparam int CW = 3;
  localparam int MAX_GUESSES = 6;
  localparam int DW = NPEGS * CW;
  localparam logic [5:0] F_START  = 6'b000001;
  localparam logic [5:0] F_INPUT  = 6'b000010;
  localparam logic [5:0] F_SCORE  = 6'b000100;
  localparam logic [5:0] F_CHECK  = 6'b001000;
  localparam logic [5:0] F_DONEC  = 6'b010000;
  localparam logic [5:0] F_DONENC = 6'b100000;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mastermind_core_p_if #(.NPEGS(NPEGS), .CW(CW), .MAX_GUESSES(MAX_GUESSES)) bus();

  mastermind_core_p #(.NPEGS(NPEGS), .CW(CW), .MAX_GUESSES(MAX_GUESSES), .CLEAR_ON_NEXT(1)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_exact_q[$];
  int exp_partial_q[$];

  function automatic logic [5:0] flags();
    return {bus.q_DoneNC, bus.q_DoneC, bus.q_Check, bus.q_Score, bus.q_Input, bus.q_Start};
  endfunction

  function automatic logic [DW-1:0] code4(input int a, input int b, input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  // Reference scoring by peg marking: exact pegs first, then unmarked colour pairings.
  function automatic void score_model(input logic [DW-1:0] g, input logic [DW-1:0] t, output int e, output int p);
    bit ug[NPEGS];
    bit ut[NPEGS];
    e = 0;
    p = 0;
    for (int i = 0; i < NPEGS; i++) begin ug[i] = 0; ut[i] = 0; end
    for (int i = 0; i < NPEGS; i++)
      if (g[i*CW +: CW] == t[i*CW +: CW]) begin e++; ug[i] = 1; ut[i] = 1; end
    for (int i = 0; i < NPEGS; i++) begin
      if (!ug[i]) begin
        for (int j = 0; j < NPEGS; j++) begin
          if (!ut[j] && g[i*CW +: CW] == t[j*CW +: CW]) begin p++; ut[j] = 1; break; end
        end
      end
    end
  endfunction

  always @(negedge Clk) begin
    n_checks++;
    if (!$onehot(flags())) begin
      n_errors++;
      $display("FAIL onehot_flags: got %b required exactly one bit set", flags());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic cf, input logic ck, input logic l, input logic r);
    bus.start = s; bus.confirm_color = cf; bus.check_guess = ck; bus.BtnL = l; bus.BtnR = r;
    tick();
    bus.start = 0; bus.confirm_color = 0; bus.check_guess = 0; bus.BtnL = 0; bus.BtnR = 0;
  endtask

  task automatic enter_guess(input logic [DW-1:0] code);
    repeat (NPEGS) pulse(0, 0, 0, 1, 0);
    for (int i = 0; i < NPEGS; i++) begin
      bus.current_color = code[i*CW +: CW];
      pulse(0, 1, 0, 0, 1);
    end
  endtask

  task automatic push_expected(input logic [DW-1:0] g, input logic [DW-1:0] t);
    int e, p;
    score_model(g, t, e, p);
    exp_exact_q.push_back(e);
    exp_partial_q.push_back(p);
  endtask

  task automatic run_guess(output int ex, output int pa, output int lat);
    bus.check_guess = 1;
    tick();
    bus.check_guess = 0;
    lat = 0;
    while (bus.score_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    ex = int'(bus.exact_cnt);
    pa = int'(bus.partial_cnt);
  endtask

  task automatic new_game_by_reset(input logic [DW-1:0] code);
    bus.correct_answer = code;
    Reset = 1;
    tick();
    Reset = 0;
    tick();
  endtask

  task automatic test_reset();
    bus.start = 0; bus.confirm_color = 0; bus.check_guess = 0; bus.BtnL = 0; bus.BtnR = 0;
    bus.current_color = '0;
    bus.correct_answer = code4(1, 2, 3, 4);
    tick(); tick();
    n_checks++; if (flags() !== F_START) begin n_errors++; $display("FAIL reset_state: got %b required %b", flags(), F_START); end
    n_checks++; if (bus.index !== '0 || bus.guess_num !== '0) begin n_errors++; $display("FAIL reset_cursor: got index=%0d guess_num=%0d required 0 0", bus.index, bus.guess_num); end
    n_checks++; if (bus.current_guess !== '0) begin n_errors++; $display("FAIL reset_guess: got %h required 0", bus.current_guess); end
    n_checks++; if (bus.exact_cnt !== '0 || bus.partial_cnt !== '0 || bus.score_valid !== 1'b0) begin n_errors++; $display("FAIL reset_score: got %0d %0d %0d required 0 0 0", bus.exact_cnt, bus.partial_cnt, bus.score_valid); end
    Reset = 0;
    tick();
    n_checks++; if (flags() !== F_INPUT) begin n_errors++; $display("FAIL reset_to_input: got %b required %b", flags(), F_INPUT); end
  endtask

  task automatic test_score_basic();
    int ex, pa, lat, e, p;
    logic [DW-1:0] g;
    g = code4(2, 1, 3, 5);
    enter_guess(g);
    push_expected(g, code4(1, 2, 3, 4));
    run_guess(ex, pa, lat);
    e = exp_exact_q.pop_front();
    p = exp_partial_q.pop_front();
    n_checks++; if (lat != 7) begin n_errors++; $display("FAIL score_latency: got %0d required 7", lat); end
    n_checks++; if (ex != e) begin n_errors++; $display("FAIL basic_exact: got %0d required %0d", ex, e); end
    n_checks++; if (pa != p) begin n_errors++; $display("FAIL basic_partial: got %0d required %0d", pa, p); end
    n_checks++; if (flags() !== F_CHECK) begin n_errors++; $display("FAIL basic_check_state: got %b required %b", flags(), F_CHECK); end
    tick();
    n_checks++; if (flags() !== F_INPUT) begin n_errors++; $display("FAIL basic_next_input: got %b required %b", flags(), F_INPUT); end
    n_checks++; if (bus.guess_num !== 3'd1 || bus.index !== 2'd0) begin n_errors++; $display("FAIL basic_next_counters: got guess_num=%0d index=%0d required 1 0", bus.guess_num, bus.index); end
    n_checks++; if (bus.current_guess !== '0) begin n_errors++; $display("FAIL basic_guess_cleared: got %h required 0", bus.current_guess); end
    n_checks++; if (bus.score_valid !== 1'b0 || int'(bus.exact_cnt) != e) begin n_errors++; $display("FAIL basic_hold: got valid=%0d exact=%0d required 0 %0d", bus.score_valid, bus.exact_cnt, e); end
  endtask

  task automatic test_duplicates();
    int ex, pa, lat, e, p;
    logic [DW-1:0] t;
    logic [DW-1:0] g [2];
    t = code4(1, 1, 2, 2);
    g[0] = code4(1, 2, 1, 3);
    g[1] = code4(1, 1, 1, 1);
    new_game_by_reset(t);
    for (int k = 0; k < 2; k++) begin
      enter_guess(g[k]);
      push_expected(g[k], t);
      run_guess(ex, pa, lat);
      e = exp_exact_q.pop_front();
      p = exp_partial_q.pop_front();
      n_checks++; if (ex != e || pa != p) begin n_errors++; $display("FAIL dup_score%0d: got %0d/%0d required %0d/%0d", k, ex, pa, e, p); end
      tick();
    end
    n_checks++; if (bus.guess_num !== 3'd2) begin n_errors++; $display("FAIL dup_guess_num: got %0d required 2", bus.guess_num); end
  endtask

  task automatic test_cursor();
    pulse(0, 0, 0, 1, 0);
    n_checks++; if (bus.index !== 2'd0) begin n_errors++; $display("FAIL cursor_left_sat: got %0d required 0", bus.index); end
    repeat (4) pulse(0, 0, 0, 0, 1);
    n_checks++; if (bus.index !== 2'd3) begin n_errors++; $display("FAIL cursor_right_sat: got %0d required 3", bus.index); end
    pulse(0, 0, 0, 1, 1);
    n_checks++; if (bus.index !== 2'd3) begin n_errors++; $display("FAIL cursor_both: got %0d required 3", bus.index); end
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0);
    bus.current_color = 3'd4;
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 1, 0, 0, 0);
    repeat (3) pulse(0, 0, 0, 0, 1);
    bus.current_color = 3'd6;
    pulse(0, 1, 0, 0, 0);
    n_checks++; if (bus.current_guess !== code4(4, 4, 0, 6)) begin n_errors++; $display("FAIL cursor_writes: got %h required %h", bus.current_guess, code4(4, 4, 0, 6)); end
    pulse(0, 0, 1, 0, 0);
    tick();
    n_checks++; if (flags() !== F_INPUT || bus.guess_num !== 3'd2) begin n_errors++; $display("FAIL check_unfilled: got %b num=%0d required %b num=2", flags(), bus.guess_num, F_INPUT); end
    pulse(1, 0, 0, 0, 0);
    tick();
    n_checks++; if (flags() !== F_INPUT) begin n_errors++; $display("FAIL start_in_input: got %b required %b", flags(), F_INPUT); end
  endtask

  task automatic test_win_restart();
    int ex, pa, lat, e, p;
    logic [DW-1:0] t2;
    new_game_by_reset(code4(1, 2, 3, 4));
    enter_guess(code4(1, 2, 3, 4));
    push_expected(code4(1, 2, 3, 4), code4(1, 2, 3, 4));
    run_guess(ex, pa, lat);
    e = exp_exact_q.pop_front();
    p = exp_partial_q.pop_front();
    n_checks++; if (ex != e || pa != p) begin n_errors++; $display("FAIL win_score: got %0d/%0d required %0d/%0d", ex, pa, e, p); end
    tick();
    tick();
    n_checks++; if (flags() !== F_DONEC || bus.exact_cnt !== 3'd4) begin n_errors++; $display("FAIL win_done: got %b exact=%0d required %b exact=4", flags(), bus.exact_cnt, F_DONEC); end
    t2 = code4(5, 5, 6, 6);
    bus.correct_answer = t2;
    pulse(1, 0, 0, 0, 0);
    n_checks++; if (flags() !== F_START) begin n_errors++; $display("FAIL restart_start: got %b required %b", flags(), F_START); end
    tick();
    n_checks++; if (flags() !== F_INPUT || bus.guess_num !== 3'd0 || bus.exact_cnt !== 3'd0) begin n_errors++; $display("FAIL restart_init: got %b num=%0d exact=%0d required %b 0 0", flags(), bus.guess_num, bus.exact_cnt, F_INPUT); end
    enter_guess(t2);
    push_expected(t2, t2);
    run_guess(ex, pa, lat);
    e = exp_exact_q.pop_front();
    p = exp_partial_q.pop_front();
    n_checks++; if (ex != e || pa != p) begin n_errors++; $display("FAIL restart_target: got %0d/%0d required %0d/%0d", ex, pa, e, p); end
    tick();
    n_checks++; if (flags() !== F_DONEC) begin n_errors++; $display("FAIL restart_win: got %b required %b", flags(), F_DONEC); end
  endtask

  task automatic test_lose();
    int ex, pa, lat, e, p;
    logic [DW-1:0] t, g;
    t = code4(1, 2, 3, 4);
    bus.correct_answer = t;
    pulse(1, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < MAX_GUESSES; k++) begin
      for (int i = 0; i < NPEGS; i++) g[i*CW +: CW] = CW'($urandom_range(1, 7));
      if (g == t) g[CW-1:0] = 3'd7;
      enter_guess(g);
      push_expected(g, t);
      run_guess(ex, pa, lat);
      e = exp_exact_q.pop_front();
      p = exp_partial_q.pop_front();
      n_checks++; if (ex != e || pa != p || lat != 7) begin n_errors++; $display("FAIL lose_score%0d: got %0d/%0d lat=%0d required %0d/%0d lat=7", k, ex, pa, lat, e, p); end
      tick();
      if (k < MAX_GUESSES - 1) begin
        n_checks++; if (flags() !== F_INPUT || int'(bus.guess_num) != k + 1) begin n_errors++; $display("FAIL lose_progress%0d: got %b num=%0d required %b num=%0d", k, flags(), bus.guess_num, F_INPUT, k + 1); end
      end
    end
    n_checks++; if (flags() !== F_DONENC || bus.guess_num !== 3'd5) begin n_errors++; $display("FAIL lose_done: got %b num=%0d required %b num=5", flags(), bus.guess_num, F_DONENC); end
    bus.current_color = 3'd7;
    pulse(0, 1, 1, 0, 1);
    tick();
    n_checks++; if (flags() !== F_DONENC || bus.index !== 2'd3 || bus.current_guess !== g) begin n_errors++; $display("FAIL lose_hold: got %b idx=%0d guess=%h required %b idx=3 guess=%h", flags(), bus.index, bus.current_guess, F_DONENC, g); end
  endtask

  task automatic test_reset_mid_score();
    int seen;
    bus.correct_answer = code4(2, 2, 3, 3);
    pulse(1, 0, 0, 0, 0);
    tick();
    enter_guess(code4(2, 3, 4, 5));
    bus.check_guess = 1;
    tick();
    bus.check_guess = 0;
    tick();
    tick();
    n_checks++; if (flags() !== F_SCORE) begin n_errors++; $display("FAIL midscore_state: got %b required %b", flags(), F_SCORE); end
    Reset = 1;
    #1;
    n_checks++; if (flags() !== F_START) begin n_errors++; $display("FAIL midscore_reset_state: got %b required %b", flags(), F_START); end
    n_checks++; if (bus.index !== '0 || bus.guess_num !== '0 || bus.current_guess !== '0 || bus.exact_cnt !== '0 || bus.partial_cnt !== '0 || bus.score_valid !== 1'b0) begin
      n_errors++; $display("FAIL midscore_outputs: got idx=%0d num=%0d guess=%h ex=%0d pa=%0d v=%0d required all 0", bus.index, bus.guess_num, bus.current_guess, bus.exact_cnt, bus.partial_cnt, bus.score_valid);
    end
    seen = 0;
    repeat (6) begin tick(); if (bus.score_valid !== 1'b0) seen++; end
    Reset = 0;
    repeat (10) begin tick(); if (bus.score_valid !== 1'b0) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL midscore_no_pulse: got %0d pulses required 0", seen); end
    n_checks++; if (flags() !== F_INPUT || bus.exact_cnt !== '0) begin n_errors++; $display("FAIL midscore_after: got %b ex=%0d required %b ex=0", flags(), bus.exact_cnt, F_INPUT); end
  endtask

  initial begin
    test_reset();
    test_score_basic();
    test_duplicates();
    test_cursor();
    test_win_restart();
    test_lose();
    test_reset_mid_score();
    n_checks++; if (exp_exact_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_exact_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
